// File: rtl/hall_decoder.sv
// rtl/hall_decoder.sv - Hall sensor synchroniser, debounce filter, sector/direction decoder and period timer
module hall_decoder #(
   parameter int FILT_LEN = 4,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                H1,
   input  logic                H2,
   input  logic                H3,
   input  logic                fault_clr,
   output logic [2:0]          hall_f,
   output logic                hall_valid,
   output logic [2:0]          sector,
   output logic                dir,
   output logic                comm_stb,
   output logic [PERIOD_W-1:0] period,
   output logic                period_vld,
   output logic                stall,
   output logic                fault
);
   localparam int                  CNT_W    = $clog2(FILT_LEN + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FILT_LEN - 1);
   localparam logic [PERIOD_W-1:0] TMAX     = '1;

   function automatic logic [2:0] sector_of(input logic [2:0] code);
      case (code)
         3'b101:  sector_of = 3'd0;
         3'b100:  sector_of = 3'd1;
         3'b110:  sector_of = 3'd2;
         3'b010:  sector_of = 3'd3;
         3'b011:  sector_of = 3'd4;
         3'b001:  sector_of = 3'd5;
         default: sector_of = 3'd7;
      endcase
   endfunction

   logic [2:0]          s1_q, s2_q;
   logic [2:0]          cand_q, cand_d, hall_q, hall_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PERIOD_W-1:0] timer_q, timer_d, period_q, period_d;
   logic                dir_q, dir_d, stb_q, stb_d, pvld_q, pvld_d;
   logic                stall_q, stall_d, fault_q, fault_d, ref_q, ref_d;
   logic                load, restart, fault_set;
   logic [2:0]          old_sec, new_sec, nxt_sec, prv_sec;

   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      hall_d    = hall_q;
      dir_d     = dir_q;
      stb_d     = 1'b0;
      period_d  = period_q;
      pvld_d    = pvld_q;
      stall_d   = stall_q;
      ref_d     = ref_q;
      timer_d   = timer_q;
      load      = 1'b0;
      restart   = 1'b0;
      fault_set = 1'b0;
      old_sec   = sector_of(hall_q);
      new_sec   = sector_of(s2_q);
      nxt_sec   = (old_sec == 3'd5) ? 3'd0 : old_sec + 3'd1;
      prv_sec   = (old_sec == 3'd0) ? 3'd5 : old_sec - 3'd1;

      // cand_q holds the code currently being counted; a different s2 value restarts the run at 1
      if (s2_q == hall_q) begin
         cnt_d = '0;
      end else if (cnt_q == '0 || s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = CNT_W'(1);
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         load  = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      if (load) begin
         hall_d  = s2_q;
         restart = 1'b1;
         if (new_sec == 3'd7) begin
            fault_set = 1'b1;
            pvld_d    = 1'b0;
            ref_d     = 1'b0;
         end else if (old_sec == 3'd7) begin
            ref_d = 1'b1;
         end else if (new_sec == nxt_sec || new_sec == prv_sec) begin
            stb_d = 1'b1;
            dir_d = (new_sec == nxt_sec);
            if (ref_q) begin
               period_d = (timer_q == TMAX) ? TMAX : timer_q + 1'b1;
               pvld_d   = ~stall_q;
            end
            stall_d = 1'b0;
            ref_d   = 1'b1;
         end else begin
            fault_set = 1'b1;
            pvld_d    = 1'b0;
            ref_d     = 1'b0;
         end
      end

      if (restart) begin
         timer_d = '0;
      end else begin
         if (timer_q != TMAX) timer_d = timer_q + 1'b1;
         if (timer_d == TMAX) begin
            stall_d = 1'b1;
            pvld_d  = 1'b0;
         end
      end

      fault_d = (fault_q & ~fault_clr) | fault_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         hall_q   <= '0;
         dir_q    <= 1'b1;
         stb_q    <= 1'b0;
         period_q <= '0;
         pvld_q   <= 1'b0;
         stall_q  <= 1'b0;
         fault_q  <= 1'b0;
         ref_q    <= 1'b0;
         timer_q  <= '0;
      end else begin
         s1_q     <= {H1, H2, H3};
         s2_q     <= s1_q;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         hall_q   <= hall_d;
         dir_q    <= dir_d;
         stb_q    <= stb_d;
         period_q <= period_d;
         pvld_q   <= pvld_d;
         stall_q  <= stall_d;
         fault_q  <= fault_d;
         ref_q    <= ref_d;
         timer_q  <= timer_d;
      end
   end

   assign hall_f     = hall_q;
   assign sector     = sector_of(hall_q);
   assign hall_valid = (sector != 3'd7);
   assign dir        = dir_q;
   assign comm_stb   = stb_q;
   assign period     = period_q;
   assign period_vld = pvld_q;
   assign stall      = stall_q;
   assign fault      = fault_q;
endmodule
